bus_rr_arbiter: RTL and testbench

- Central bus stage between the per-device input FIFOs (drained via Pndng/Pop/D_pop) and the per-device output FIFOs (filled via Push_int/D_in_int, throttled by Full_out).
- Selects one pending source round-robin, pops one packet and decodes the destination ID from the packet header.
- Delivers the packet to one output FIFO, or to all of them except the source for broadcast.
- One packet is in flight at a time; the block keeps delivered and dropped packet counters.

---
 rtl/bus_pkg.sv | 35 +++
 rtl/bus_rr_arbiter_rr_pick.sv | 32 +++
 rtl/bus_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_rr_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus round-robin arbiter: FSM state encoding,
// default ID field settings and the packet header decode helper.
package bus_pkg;

    // Legacy-compatible state codes, also exposed as an enum for the FSM.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_POP     = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        POP     = ST_POP,
        DELIVER = ST_DELIVER
    } state_t;

    // Default destination ID width and the broadcast ID for that width.
    localparam int         DEF_ID_W      = 8;
    localparam logic [7:0] DEF_BROADCAST = 8'hFF;

    // Upper bounds used by the width-generic header decode below.
    localparam int MAX_PKT_W = 256;
    localparam int MAX_ID_W  = 32;

    // Destination ID lives in the top id_w bits of the packet.
    function automatic logic [MAX_ID_W-1:0] pkt_dest(
        input logic [MAX_PKT_W-1:0] pkt,
        input int unsigned          pkt_w,
        input int unsigned          idw
    );
        logic [MAX_PKT_W-1:0] sh;
        sh = pkt >> (pkt_w - idw);
        return sh[MAX_ID_W-1:0] & ((MAX_ID_W'(1) << idw) - MAX_ID_W'(1));
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: starting just after the last grant,
// returns the first requesting index (with wrap-around) and a valid flag.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   last,
    output logic [3:0]   idx,
    output logic         valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    int cand;

    // Scan last+1 .. last+N (mod N); the last grant is therefore checked last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!valid && req[IW'(cand)]) begin
                idx   = 4'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Central bus stage: picks a pending input FIFO round-robin, pops one packet,
// decodes its destination and pushes it to one output FIFO (or to all other
// FIFOs for broadcast). One packet in flight; delivered/dropped counters.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int               drvrs     = 4,
    parameter int               pckg_sz   = 32,
    parameter int               id_w      = DEF_ID_W,
    parameter logic [id_w-1:0]  broadcast = {id_w{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           Pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           Pop,
    input  logic [drvrs-1:0]           Full_out,
    output logic [drvrs-1:0]           Push_int,
    output logic [drvrs*pckg_sz-1:0]   D_in_int,
    output logic                       busy,
    output logic [3:0]                 grant_id,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    state_t             state;
    logic [pckg_sz-1:0] pkt_p1;
    logic [pckg_sz-1:0] pop_words [drvrs];
    logic [IW-1:0]      gidx;
    logic [3:0]         pick_idx;
    logic               pick_vld;
    logic [id_w-1:0]    dest;
    logic [drvrs-1:0]   tgt_mask;
    logic               is_drop;
    logic               deliver_ok;

    assign gidx = grant_id[IW-1:0];

    // Unpack input heads and fan the latched packet out to every output slice.
    for (genvar g = 0; g < drvrs; g++) begin : g_slices
        assign pop_words[g]                        = D_pop[g*pckg_sz +: pckg_sz];
        assign D_in_int[g*pckg_sz +: pckg_sz]      = pkt_p1;
    end

    rr_pick #(
        .N(drvrs)
    ) u_pick (
        .req   (Pndng),
        .last  (grant_id),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    assign dest = id_w'(pkt_dest(MAX_PKT_W'(pkt_p1), pckg_sz, id_w));

    // Target set: everyone but the source for broadcast, else the addressed
    // in-range device unless it is the source itself (empty set = drop).
    always_comb begin
        tgt_mask = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (dest == broadcast) begin
                tgt_mask[i] = (i != int'(grant_id));
            end else begin
                tgt_mask[i] = (int'(dest) == i) && (i != int'(grant_id));
            end
        end
    end

    // Broadcast is all-or-nothing: every target must be non-full together.
    assign is_drop    = ~|tgt_mask;
    assign deliver_ok = (state == DELIVER) && !is_drop && ~|(tgt_mask & Full_out);
    assign Push_int   = deliver_ok ? tgt_mask : '0;
    assign busy       = (state != IDLE);

    // Arbitration FSM: IDLE -> POP (one-cycle pop strobe) -> DELIVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= 4'(drvrs - 1);
            Pop      <= '0;
            pkt_p1   <= '0;
        end else begin
            Pop <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick_idx;
                        Pop      <= drvrs'(1) << pick_idx;
                        state    <= POP;
                    end
                end
                POP: begin
                    pkt_p1 <= pop_words[gidx];
                    state  <= DELIVER;
                end
                DELIVER: begin
                    if (is_drop || deliver_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating delivered/dropped packet counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (state == DELIVER) begin
            if (is_drop) begin
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else if (deliver_ok) begin
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with a push scoreboard.
module tb_bus_rr_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   Pndng;
    logic [127:0] D_pop;
    logic [3:0]   Pop;
    logic [3:0]   Full_out;
    logic [3:0]   Push_int;
    logic [127:0] D_in_int;
    logic         busy;
    logic [3:0]   grant_id;
    logic [15:0]  pkt_cnt;
    logic [15:0]  drop_cnt;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bus_rr_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .Pndng    (Pndng),
        .D_pop    (D_pop),
        .Pop      (Pop),
        .Full_out (Full_out),
        .Push_int (Push_int),
        .D_in_int (D_in_int),
        .busy     (busy),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every push must match the oldest expected push.
    always @(negedge clk) begin
        if (!reset) begin
            chk("pop_push_excl", {63'd0, (|Pop) && (|Push_int)}, 64'd0);
            chk("pop_onehot0", {63'd0, $countones(Pop) <= 1}, 64'd1);
            if (Push_int != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_push", {60'd0, Push_int}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_mask", {60'd0, Push_int}, {60'd0, e.mask});
                    for (int i = 0; i < 4; i++) begin
                        if (e.mask[i]) chk("sb_data", {32'd0, D_in_int[i*32 +: 32]}, {32'd0, e.data});
                    end
                end
            end
        end
    end

    // One packet from src; fc DELIVER cycles with fmask full before release.
    task automatic send(input int src, input logic [31:0] data, input logic [3:0] mask,
                        input int fc, input logic [3:0] fmask);
        logic [3:0] one;
        exp_t e;
        one = 4'b0001 << src;
        tick();
        Pndng[src] = 1'b1;
        D_pop[src*32 +: 32] = data;
        Full_out = (fc > 0) ? fmask : 4'd0;
        if (mask != 4'd0) begin
            e.mask = mask;
            e.data = data;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_pop", {60'd0, Pop}, 64'd0);
        tick();
        Pndng[src] = 1'b0;
        @(negedge clk);
        chk("pop_strobe", {60'd0, Pop}, {60'd0, one});
        chk("grant", {60'd0, grant_id}, 64'(src));
        chk("pop_nopush", {60'd0, Push_int}, 64'd0);
        for (int k = 0; k < fc; k++) begin
            if (k > 0) tick();
            if (k > 0) @(negedge clk);
            else @(negedge clk);
            chk("bp_hold", {60'd0, Push_int}, 64'd0);
            chk("bp_busy", {63'd0, busy}, 64'd1);
            chk("bp_nopop", {60'd0, Pop}, 64'd0);
        end
        tick();
        Full_out = 4'd0;
        @(negedge clk);
        chk("deliver_push", {60'd0, Push_int}, {60'd0, mask});
        tick();
        @(negedge clk);
        chk("back_idle", {63'd0, busy}, 64'd0);
        chk("back_nopush", {60'd0, Push_int}, 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [31:0] w;
        reset    = 1'b1;
        Pndng    = '0;
        D_pop    = '0;
        Full_out = '0;
        #3;
        chk("rst_pop", {60'd0, Pop}, 64'd0);
        chk("rst_push", {60'd0, Push_int}, 64'd0);
        chk("rst_din", {63'd0, |D_in_int}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant", {60'd0, grant_id}, 64'd3);
        chk("rst_pkt", {48'd0, pkt_cnt}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt}, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);

        // Round-robin with all sources pending, src i -> dest (i+1)%4.
        tick();
        Pndng = 4'hF;
        for (int i = 0; i < 4; i++) begin
            w = {8'((i + 1) % 4), 24'(24'hA00000 + i)};
            D_pop[i*32 +: 32] = w;
        end
        for (int n = 0; n < 5; n++) begin
            e.mask = 4'b0001 << ((n + 1) % 4);
            e.data = D_pop[(n % 4)*32 +: 32];
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("rr_idle", {63'd0, busy}, 64'd0);
        for (int n = 0; n < 5; n++) begin
            tick();
            @(negedge clk);
            chk("rr_pop", {60'd0, Pop}, {60'd0, 4'b0001 << (n % 4)});
            chk("rr_grant", {60'd0, grant_id}, 64'(n % 4));
            tick();
            @(negedge clk);
            chk("rr_push", {60'd0, Push_int}, {60'd0, 4'b0001 << ((n + 1) % 4)});
            chk("rr_push_nopop", {60'd0, Pop}, 64'd0);
            tick();
            if (n == 4) Pndng = 4'd0;
            @(negedge clk);
            chk("rr_back_idle", {63'd0, busy}, 64'd0);
        end
        chk("rr_pkt_cnt", {48'd0, pkt_cnt}, 64'd5);

        // Single unicast 0 -> 2.
        send(0, 32'h0200ABCD, 4'b0100, 0, 4'd0);
        chk("uni_pkt_cnt", {48'd0, pkt_cnt}, 64'd6);

        // Backpressure: 1 -> 3 with output 3 full for 5 cycles.
        send(1, 32'h03C0FFEE, 4'b1000, 5, 4'b1000);
        chk("bp_pkt_cnt", {48'd0, pkt_cnt}, 64'd7);

        // Atomic broadcast from 2 with output 0 full for 2 cycles.
        send(2, 32'hFF001234, 4'b1011, 2, 4'b0001);
        chk("bc_pkt_cnt", {48'd0, pkt_cnt}, 64'd8);

        // Drops: out-of-range dest, then self-addressed.
        send(0, 32'h07112233, 4'b0000, 0, 4'd0);
        send(1, 32'h01445566, 4'b0000, 0, 4'd0);
        chk("drop_cnt", {48'd0, drop_cnt}, 64'd2);
        chk("drop_pkt_cnt", {48'd0, pkt_cnt}, 64'd8);

        // Async reset while stuck in DELIVER on a full target.
        tick();
        Pndng[1] = 1'b1;
        D_pop[32 +: 32] = 32'h03DEAD01;
        Full_out = 4'b1000;
        @(negedge clk);
        tick();
        Pndng[1] = 1'b0;
        @(negedge clk);
        chk("ar_pop", {60'd0, Pop}, 64'd2);
        tick();
        @(negedge clk);
        chk("ar_held", {60'd0, Push_int}, 64'd0);
        chk("ar_busy", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_rst_busy", {63'd0, busy}, 64'd0);
        chk("ar_rst_push", {60'd0, Push_int}, 64'd0);
        chk("ar_rst_pop", {60'd0, Pop}, 64'd0);
        chk("ar_rst_din", {63'd0, |D_in_int}, 64'd0);
        chk("ar_rst_grant", {60'd0, grant_id}, 64'd3);
        chk("ar_rst_pkt", {48'd0, pkt_cnt}, 64'd0);
        chk("ar_rst_drop", {48'd0, drop_cnt}, 64'd0);
        #1;
        reset = 1'b0;
        Full_out = 4'd0;
        @(negedge clk);
        send(0, 32'h02777777, 4'b0100, 0, 4'd0);
        chk("ar_after_pkt", {48'd0, pkt_cnt}, 64'd1);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
